// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Address width is derived from the register count so every file agrees on it.
package regfile_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int NUM_REGS_DEF   = 32;
    localparam int NUM_RPORTS_DEF = 2;
    localparam int REG_ZERO       = 0;

    function automatic int addr_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count.
// Issue outranks a same-cycle writeback; flush and reset clear everything.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_rd,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     pend_cnt
);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [ADDR_W:0]     pend_cnt_r;
    logic                rise_s;
    logic                fall_s;

    // Next busy vector from issue/writeback priority (x0 never busy)
    always_comb begin
        busy_next_s = busy_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r == REG_ZERO) begin
                busy_next_s[r] = 1'b0;
            end else if (iss_en && (iss_rd == ADDR_W'(r))) begin
                busy_next_s[r] = 1'b1;
            end else if (wb_en && (wb_addr == ADDR_W'(r))) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
    end

    // Single-cycle 0->1 and 1->0 transitions that drive the incremental count
    always_comb begin
        rise_s = iss_en && (iss_rd != ADDR_W'(REG_ZERO)) && !busy_r[iss_rd];
        fall_s = wb_en && (wb_addr != ADDR_W'(REG_ZERO)) && busy_r[wb_addr]
                 && !(iss_en && (iss_rd == wb_addr));
    end

    // Busy bits and pending count state
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_r     <= {NUM_REGS{1'b0}};
            pend_cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r <= busy_next_s;
            case ({rise_s, fall_s})
                2'b10:   pend_cnt_r <= pend_cnt_r + (ADDR_W+1)'(1);
                2'b01:   pend_cnt_r <= pend_cnt_r - (ADDR_W+1)'(1);
                default: pend_cnt_r <= pend_cnt_r;
            endcase
        end
    end

    assign busy     = busy_r;
    assign pend_cnt = pend_cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Single-write, multi-read register file with writeback bypass, hardwired x0
// and a pending-write scoreboard for decode hazard detection.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN       = XLEN_DEF,
    parameter  int NUM_REGS   = NUM_REGS_DEF,
    parameter  int NUM_RPORTS = NUM_RPORTS_DEF,
    localparam int ADDR_W     = addr_w(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         iss_en,
    input  logic [ADDR_W-1:0]            iss_rd,
    input  logic                         flush,
    input  logic [NUM_RPORTS*ADDR_W-1:0] rs_addr,
    output logic [NUM_RPORTS*XLEN-1:0]   rs_data,
    output logic [NUM_RPORTS-1:0]        rs_busy,
    output logic [ADDR_W:0]              pend_cnt
);

    logic [XLEN-1:0]     regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_s;

    // Data array; x0 is never written so it stays at its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
        end else if (wb_en && (wb_addr != ADDR_W'(REG_ZERO))) begin
            regs_r[wb_addr] <= wb_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    regfile_sb_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy     (busy_s),
        .pend_cnt (pend_cnt)
    );

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [XLEN-1:0]   data_s;
        logic              busy_p_s;

        assign addr_s = rs_addr[p*ADDR_W +: ADDR_W];

        // Read mux: x0, then same-cycle writeback bypass, then the array
        always_comb begin
            if (addr_s == ADDR_W'(REG_ZERO)) begin
                data_s   = {XLEN{1'b0}};
                busy_p_s = 1'b0;
            end else if (wb_en && (wb_addr == addr_s)) begin
                data_s   = wb_data;
                busy_p_s = 1'b0;
            end else begin
                data_s   = regs_r[addr_s];
                busy_p_s = busy_s[addr_s];
            end
        end

        assign rs_data[p*XLEN +: XLEN] = data_s;
        assign rs_busy[p]              = busy_p_s;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized run
// against an array-based reference model of registers and pending writes.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int NP   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             iss_en;
    logic [AW-1:0]    iss_rd;
    logic             flush;
    logic [NP*AW-1:0] rs_addr;
    logic [NP*XLEN-1:0] rs_data;
    logic [NP-1:0]    rs_busy;
    logic [AW:0]      pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] mdl_regs [NR];
    bit              mdl_busy [NR];

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RPORTS(NP)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    function automatic int mdl_pend();
        int c = 0;
        for (int r = 0; r < NR; r++) c += int'(mdl_busy[r]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] mdl_rdata(input int a);
        if (a == 0) return '0;
        if (wb_en && int'(wb_addr) == a) return wb_data;
        return mdl_regs[a];
    endfunction

    function automatic bit mdl_rbusy(input int a);
        if (a == 0) return 1'b0;
        if (wb_en && int'(wb_addr) == a) return 1'b0;
        return mdl_busy[a];
    endfunction

    // Apply the architectural rules for the inputs present at this edge
    task automatic mdl_commit();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                mdl_regs[r] = '0;
                mdl_busy[r] = 1'b0;
            end
        end else begin
            if (wb_en && wb_addr != 0) mdl_regs[wb_addr] = wb_data;
            if (flush) begin
                for (int r = 0; r < NR; r++) mdl_busy[r] = 1'b0;
            end else begin
                if (wb_en && wb_addr != 0) mdl_busy[wb_addr] = 1'b0;
                if (iss_en && iss_rd != 0) mdl_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        mdl_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic set_rs(input int a0, input int a1);
        rs_addr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        idle();
        set_rs(5, 31);
        n_checks++;
        if (rs_data !== 64'h0 || rs_busy !== 2'b00 || pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset: data=%h busy=%b pend=%0d required data=0 busy=00 pend=0",
                     rs_data, rs_busy, pend_cnt);
        end
    endtask

    task automatic test_write_read();
        idle();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
        tick();
        wb_addr = 5'd0; wb_data = 32'h12345678;
        tick();
        idle();
        set_rs(3, 0);
        n_checks++;
        if (rs_data[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read_x3: got %h required deadbeef", rs_data[31:0]);
        end
        n_checks++;
        if (rs_data[63:32] !== 32'h0) begin
            n_fail++;
            $display("FAIL write_read_x0: got %h required 00000000", rs_data[63:32]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5A5A5;
        set_rs(7, 7);
        n_checks++;
        if (rs_data !== {2{32'hA5A5A5A5}}) begin
            n_fail++;
            $display("FAIL bypass: got %h required a5a5a5a5a5a5a5a5", rs_data);
        end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en = 1'b1; iss_rd = 5'd4;
        tick();
        idle();
        set_rs(4, 0);
        n_checks++;
        if (rs_busy !== 2'b01 || pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL issue_x4: busy=%b pend=%0d required busy=01 pend=1", rs_busy, pend_cnt);
        end
        iss_en = 1'b1; iss_rd = 5'd4;
        tick();
        idle();
        n_checks++;
        if (pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL reissue_x4: pend=%0d required 1", pend_cnt);
        end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h00C0FFEE;
        set_rs(4, 4);
        n_checks++;
        if (rs_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL wb_resolves_x4: busy=%b required 00", rs_busy);
        end
        tick();
        idle();
        n_checks++;
        if (pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL wb_x4_pend: pend=%0d required 0", pend_cnt);
        end
    endtask

    task automatic test_issue_wb_same();
        idle();
        iss_en = 1'b1; iss_rd = 5'd9;
        tick();
        iss_en = 1'b1; iss_rd = 5'd9;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h13579BDF;
        tick();
        idle();
        set_rs(9, 0);
        n_checks++;
        if (rs_busy[0] !== 1'b1 || rs_data[31:0] !== 32'h13579BDF || pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL issue_wb_x9: busy=%b data=%h pend=%0d required busy=1 data=13579bdf pend=1",
                     rs_busy[0], rs_data[31:0], pend_cnt);
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h2468ACE0;
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int r = 1; r <= 3; r++) begin
            iss_en = 1'b1; iss_rd = AW'(r);
            tick();
        end
        idle();
        n_checks++;
        if (pend_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL pend_three: pend=%0d required 3", pend_cnt);
        end
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd5;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0F1E2D3C;
        tick();
        idle();
        set_rs(5, 1);
        n_checks++;
        if (pend_cnt !== 6'd0 || rs_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL flush: pend=%0d busy=%b required pend=0 busy=00", pend_cnt, rs_busy);
        end
        set_rs(2, 3);
        n_checks++;
        if (rs_data[31:0] !== 32'h0F1E2D3C || rs_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_wb_commit: data=%h busy=%b required data=0f1e2d3c busy=00",
                     rs_data[31:0], rs_busy);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        iss_en = 1'b1; iss_rd = 5'd8;
        tick();
        rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hCAFEF00D;
        iss_en = 1'b1; iss_rd = 5'd6;
        set_rs(6, 8);
        n_checks++;
        if (rs_data[31:0] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL reset_cycle_bypass: got %h required cafef00d", rs_data[31:0]);
        end
        tick();
        idle();
        set_rs(6, 8);
        n_checks++;
        if (rs_data !== 64'h0 || rs_busy !== 2'b00 || pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid: data=%h busy=%b pend=%0d required 0/00/0",
                     rs_data, rs_busy, pend_cnt);
        end
    endtask

    task automatic test_random();
        int a0, a1;
        logic [XLEN-1:0] e0, e1;
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            flush   = ($urandom_range(0, 29) == 0);
            wb_en   = $urandom_range(0, 1) == 1;
            wb_addr = AW'($urandom_range(0, 7));
            wb_data = $urandom;
            iss_en  = $urandom_range(0, 1) == 1;
            iss_rd  = AW'($urandom_range(0, 7));
            a0 = $urandom_range(0, 7);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, 31));
            set_rs(a0, a1);
            e0 = mdl_rdata(a0);
            e1 = mdl_rdata(a1);
            n_checks++;
            if (rs_data !== {e1, e0} || rs_busy !== {mdl_rbusy(a1), mdl_rbusy(a0)}) begin
                n_fail++;
                $display("FAIL rand_read[%0d]: a=%0d/%0d data=%h busy=%b required data=%h busy=%b",
                         i, a0, a1, rs_data, rs_busy, {e1, e0}, {mdl_rbusy(a1), mdl_rbusy(a0)});
            end
            tick();
            n_checks++;
            if (int'(pend_cnt) != mdl_pend()) begin
                n_fail++;
                $display("FAIL rand_pend[%0d]: pend=%0d required %0d", i, pend_cnt, mdl_pend());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rs_addr = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_issue_wb_same();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's single-write, two-read register file.
- Generalised in data width, register count and number of read ports.
- Adds write-to-read bypass, a hardwired-zero x0, a per-register pending-write scoreboard (busy bits) for decode-stage hazard detection, a pipeline flush, and an outstanding-write counter.
- Sits between decode (issue/read) and writeback.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >=2); ADDR_W = $clog2(NUM_REGS)
NUM_RPORTS, 2, number of combinational read ports (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
wb_en  in  1  writeback valid
wb_addr  in  ADDR_W  writeback destination
wb_data  in  XLEN  writeback data
iss_en  in  1  instruction issued with a destination register
iss_rd  in  ADDR_W  destination of issued instruction
flush  in  1  discard all pending writes (pipeline flush)
rs_addr  in  NUM_RPORTS*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
rs_data  out  NUM_RPORTS*XLEN  read data, port p at [p*XLEN +: XLEN]
rs_busy  out  NUM_RPORTS  port p source still has an outstanding producer
pend_cnt  out  ADDR_W+1  number of registers currently marked busy

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset: all registers = 0, all busy bits = 0, pend_cnt = 0. rs_data then reads 0 and rs_busy reads 0 for every port, apart from bypass during the reset cycle itself.
- Reset mid-operation:
  - An rst cycle overrides wb_en, iss_en and flush. The write is dropped and no busy bit is set.
  - The bypass still drives rs_data combinationally in that cycle.
- x0 (address 0):
  - Always reads 0 and is never busy.
  - Writes to it are ignored; issue to it is ignored.
- Write: on posedge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data. Otherwise the register holds.
- Read: combinational, 0-cycle latency. Per port p with address a:
  - if a==0: rs_data=0
  - else if wb_en && wb_addr==a: rs_data = wb_data (bypass)
  - else: rs_data = reg[a]
- Busy update, per register r!=0, evaluated at posedge in this priority order:
  1. rst: busy <= 0.
  2. flush: busy <= 0 for all registers. iss_en that cycle is ignored; the wb write still commits data.
  3. iss_en && iss_rd==r: busy <= 1. Issue beats a same-cycle writeback to the same register, because a new producer is now in flight.
  4. wb_en && wb_addr==r: busy <= 0.
  5. Otherwise busy holds.
- rs_busy[p] = (a!=0) && busy[a] && !(wb_en && wb_addr==a). A same-cycle writeback resolves the hazard. A same-cycle issue does not affect rs_busy until the next cycle.
- Scoreboard semantics:
  - Issue to an already-busy register keeps busy=1; single outstanding producer per register.
  - Writeback to a non-busy register writes the data and leaves busy=0; no error.
- pend_cnt:
  - Registered; equals the popcount of the busy bits after each posedge.
  - Maintained incrementally: +1 when a 0->1 busy transition occurs, -1 when a 1->0 transition occurs, both in the same cycle nets 0.
  - Set to 0 on rst or flush.
  - Never exceeds NUM_REGS-1.
- Read ports are independent. Duplicate addresses on several ports return identical results.

Decomposition:
- Shared package regfile_pkg:
  - XLEN/NUM_REGS defaults
  - ADDR_W derivation function
  - REG_ZERO = 0 constant
- One natural sub-module: regfile_sb_scoreboard.
  - Holds the busy-bit vector, issue/writeback/flush priority and pend_cnt.
  - Instantiated once.
- The data array and read/bypass muxes stay in regfile_sb. The read mux is a generate loop over NUM_RPORTS.

Test Plan:
- Reset then read: rst=1 one cycle; read ports 0 and 1 with addresses 5 and 31 -> rs_data=0, rs_busy=0, pend_cnt=0.
- Write/read and x0: wb x3<=0xDEADBEEF, then x0<=0x12345678; next cycle read x3, x0 -> 0xDEADBEEF, 0x00000000.
- Bypass: wb_en=1, wb_addr=7, wb_data=0xA5A5A5A5 while rs_addr=7 on both ports in the same cycle -> both rs_data=0xA5A5A5A5 before the clock edge.
- Scoreboard:
  - issue x4 -> next cycle rs_busy=1 for x4, pend_cnt=1.
  - issue x4 again -> pend_cnt stays 1.
  - wb x4 -> rs_busy=0 during the wb cycle, pend_cnt=0 after.
- Simultaneous issue+wb to x9 when x9 busy -> x9 stays busy, data updated, pend_cnt unchanged.
- Flush and mid-operation reset:
  - issue x1, x2, x3 (pend_cnt=3), then flush with iss_en to x5 -> all busy=0, pend_cnt=0, x5 not busy.
  - rst with wb_en to x6 -> x6 reads 0 afterwards.
